// File: rtl/axi_read_error_responder.sv
// axi_read_error_responder: emits the DECERR read burst for an unmapped AR once legitimate reads drain
// Ports:
//    clk, rst_n            clock, synchronous active-low reset
//    sample_ardata_info_i  capture strobe for arid_i/arlen_i/aruser_i (honoured only when idle)
//    outstanding_trans_i   high while legitimate reads are still pending on this port
//    rvalid_o/rready_i     R-channel handshake toward the R allocator
//    rid_o, rdata_o, rresp_o, rlast_o, ruser_o  R-channel payload
//    error_gnt_o           one-cycle grant on the last beat, releases the decoder
//    busy_o                high whenever the responder is not idle
module axi_read_error_responder #(
   parameter int AXI_ID_WIDTH = 6,
   parameter int AXI_DATA_W   = 64,
   parameter int AXI_USER_W   = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sample_ardata_info_i,
   input  logic [AXI_ID_WIDTH-1:0] arid_i,
   input  logic [7:0]              arlen_i,
   input  logic [AXI_USER_W-1:0]   aruser_i,
   input  logic                    outstanding_trans_i,
   output logic                    rvalid_o,
   input  logic                    rready_i,
   output logic [AXI_ID_WIDTH-1:0] rid_o,
   output logic [AXI_DATA_W-1:0]   rdata_o,
   output logic [1:0]              rresp_o,
   output logic                    rlast_o,
   output logic [AXI_USER_W-1:0]   ruser_o,
   output logic                    error_gnt_o,
   output logic                    busy_o
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] SEND  = 2'd2;
   logic [1:0]              state;
   logic [7:0]              beat_cnt;
   logic [7:0]              len_q;
   logic [AXI_ID_WIDTH-1:0] id_q;
   logic [AXI_USER_W-1:0]   user_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         beat_cnt <= '0;
         len_q    <= '0;
         id_q     <= '0;
         user_q   <= '0;
      end else begin
         case (state)
            IDLE: if (sample_ardata_info_i) begin
               id_q   <= arid_i;
               len_q  <= arlen_i;
               user_q <= aruser_i;
               state  <= DRAIN;
            end
            DRAIN: if (!outstanding_trans_i) begin
               beat_cnt <= '0;
               state    <= SEND;
            end
            SEND: if (rready_i) begin
               // the compare against len_q ends the burst before beat_cnt could wrap
               if (beat_cnt == len_q) state <= IDLE;
               else beat_cnt <= beat_cnt + 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign rvalid_o    = state == SEND;
   assign rlast_o     = rvalid_o && beat_cnt == len_q;
   assign rresp_o     = rvalid_o ? 2'b11 : 2'b00;
   assign rdata_o     = '0;
   assign rid_o       = id_q;
   assign ruser_o     = user_q;
   assign error_gnt_o = rvalid_o && rready_i && rlast_o;
   assign busy_o      = state != IDLE;
endmodule

// File: tb/tb_axi_read_error_responder.sv
// tb_axi_read_error_responder: randomized and directed checks of the DECERR read responder
module tb_axi_read_error_responder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample = 1'b0;
   logic [5:0]  arid = '0;
   logic [7:0]  arlen = '0;
   logic [5:0]  aruser = '0;
   logic        outstanding = 1'b0;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [5:0]  rid;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic [5:0]  ruser;
   logic        gnt;
   logic        busy;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   axi_read_error_responder dut (
      .clk(clk), .rst_n(rst_n), .sample_ardata_info_i(sample), .arid_i(arid),
      .arlen_i(arlen), .aruser_i(aruser), .outstanding_trans_i(outstanding),
      .rvalid_o(rvalid), .rready_i(rready), .rid_o(rid), .rdata_o(rdata),
      .rresp_o(rresp), .rlast_o(rlast), .ruser_o(ruser), .error_gnt_o(gnt), .busy_o(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rvalid"}, rvalid, 0);
      chk({tag, "_rlast"}, rlast, 0);
      chk({tag, "_rresp"}, rresp, 0);
      chk({tag, "_rid"}, rid, 0);
      chk({tag, "_ruser"}, ruser, 0);
      chk({tag, "_rdata"}, rdata, 0);
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // Reference: an accepted request yields exactly len+1 DECERR beats carrying its id/user,
   // last flag only on beat len+1, one grant on that final handshake, first beat two cycles
   // after the strobe once nothing is outstanding, and no dropped valid without a handshake.
   task automatic run_burst(input logic [5:0] id, input logic [7:0] len, input logic [5:0] user,
                            input int drain, input int pct, input bit spur);
      int   hs;
      int   gnt_n;
      int   cyc;
      logic rr;
      @(negedge clk);
      sample = 1'b1; arid = id; arlen = len; aruser = user;
      outstanding = drain > 0; rready = 1'b0;
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_rvalid", rvalid, 0);
      for (int i = 0; i < drain; i++) begin
         @(negedge clk);
         sample = spur && i == 0;
         arid = 6'h01; arlen = 8'd0; aruser = 6'h00;
         #1;
         chk("drain_rvalid", rvalid, 0);
         chk("drain_busy", busy, 1);
      end
      @(negedge clk);
      sample = 1'b0; outstanding = 1'b0;
      #1;
      chk("pre_rvalid", rvalid, 0);
      chk("pre_busy", busy, 1);
      hs = 0; gnt_n = 0; cyc = 0;
      while (hs <= int'(len) && cyc < 2000) begin
         @(negedge clk);
         rr = pct >= 100 ? 1'b1 : ($urandom_range(99) < pct);
         rready = rr;
         outstanding = 1'($urandom_range(1));
         #1;
         chk("beat_rvalid", rvalid, 1);
         chk("beat_rid", rid, id);
         chk("beat_ruser", ruser, user);
         chk("beat_rresp", rresp, 2'b11);
         chk("beat_rdata", rdata, 0);
         chk("beat_rlast", rlast, hs == int'(len));
         chk("beat_gnt", gnt, rr && hs == int'(len));
         if (gnt) gnt_n++;
         if (rvalid && rr) hs++;
         cyc++;
      end
      chk("burst_beats", hs, int'(len) + 1);
      chk("burst_gnt_count", gnt_n, 1);
      @(negedge clk);
      rready = 1'b0; outstanding = 1'b0;
      #1;
      chk("post_busy", busy, 0);
      chk("post_rvalid", rvalid, 0);
      chk("post_gnt", gnt, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk_all_zero("after_release");
      run_burst(6'h15, 8'd0, 6'h2a, 0, 100, 1'b0);
      run_burst(6'h22, 8'd3, 6'h11, 10, 100, 1'b0);
      run_burst(6'h0c, 8'd2, 6'h33, 0, 50, 1'b0);
      run_burst(6'h3f, 8'd255, 6'h3f, 1, 100, 1'b0);
      run_burst(6'h2e, 8'd3, 6'h05, 3, 100, 1'b1);
      for (int k = 0; k < 15; k++) begin
         int d;
         d = $urandom_range(3);
         run_burst(6'($urandom), 8'($urandom_range(7)), 6'($urandom), d,
                   $urandom_range(30, 100), d > 0 && $urandom_range(1) == 1);
      end
      @(negedge clk);
      sample = 1'b1; arid = 6'h2b; arlen = 8'd4; aruser = 6'h19; outstanding = 1'b0;
      @(negedge clk);
      sample = 1'b0;
      @(negedge clk);
      rready = 1'b1;
      #1 chk("rst_burst_beat1", rvalid, 1);
      @(negedge clk);
      #1 chk("rst_burst_beat2", rvalid, 1);
      rst_n = 1'b0;
      @(negedge clk);
      #1 chk_all_zero("mid_reset");
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk("post_reset_rvalid", rvalid, 0);
         chk("post_reset_gnt", gnt, 0);
         chk("post_reset_busy", busy, 0);
      end
      rready = 1'b0;
      run_burst(6'h07, 8'd1, 6'h0e, 2, 70, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
